wash_controller: RTL and testbench

- Cycle-sequencing FSM for the washing machine.
- Drives the phase timer's state and start inputs, and consumes its Finished flag.
- Runs the wash cycle from coin insertion to completion: Filling_water, Washing, Rinsing, Spinning, then back to Idle.
- Also handles pause during spin, cancel, an optional double wash, and the door lock.

---
 rtl/wash_controller_if.sv | 56 +++++
 rtl/wash_controller.sv | 190 +++++++++++++++++++
 tb/tb_wash_controller.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wash_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : wash_controller_if
// Description : Signal bundle between the wash-cycle sequencer and its
//               surroundings (coin slot, front panel, phase timer, door).
//               The slave modport is the controller's view. The master
//               modport is the environment's view.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   coin_in      environment -> ctrl  level, starts a cycle from Idle
//   double_wash  environment -> ctrl  sampled at coin acceptance
//   timer_pause  environment -> ctrl  level, pause request (Spinning only)
//   cancel       environment -> ctrl  level, abort request
//   timer_done   environment -> ctrl  Finished flag of the phase timer
//   state        ctrl -> environment  3-bit phase code to the timer
//   start_timer  ctrl -> environment  one-cycle timer restart pulse
//   wash_done    ctrl -> environment  one-cycle normal-completion pulse
//   door_lock    ctrl -> environment  high whenever state is not Idle
// ============================================================================
interface wash_controller_if;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic       cancel;
  logic       timer_done;
  logic [2:0] state;
  logic       start_timer;
  logic       wash_done;
  logic       door_lock;

  modport slave (
    input  coin_in,
    input  double_wash,
    input  timer_pause,
    input  cancel,
    input  timer_done,
    output state,
    output start_timer,
    output wash_done,
    output door_lock
  );

  modport master (
    output coin_in,
    output double_wash,
    output timer_pause,
    output cancel,
    output timer_done,
    input  state,
    input  start_timer,
    input  wash_done,
    input  door_lock
  );
endinterface
`default_nettype wire

// File: rtl/wash_controller.sv
`default_nettype none
// ============================================================================
// Module      : wash_controller
// Description : Cycle-sequencing FSM for the washing machine. It steps
//               through Filling_water, Washing, Rinsing and Spinning, and
//               restarts the external phase timer on every timed-phase
//               entry. It also handles pause during spin, cancel (drain
//               spin), the door lock and an optional double wash.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   GUARD_CYCLES  cycles after each start_timer pulse during which
//                 timer_done is ignored (legal range 2..7, default 2)
// Ports:
//   clk    system clock (shared with the phase timer)
//   rst_n  asynchronous active-low reset
//   bus    wash_controller_if.slave: coin_in, double_wash, timer_pause,
//          cancel, timer_done in; state, start_timer, wash_done,
//          door_lock out (all outputs registered)
// Configuration macro:
//   DOUBLE_WASH_EN  when defined, double_wash latched at coin acceptance
//                   adds one extra Washing+Rinsing pair before Spinning
// ============================================================================
module wash_controller #(
  parameter int GUARD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  wash_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FILL  = 3'b001,
    WASH  = 3'b010,
    RINSE = 3'b011,
    SPIN  = 3'b100,
    PAUSE = 3'b101
  } state_t;

  localparam logic [2:0] GUARD_LOAD = 3'(GUARD_CYCLES);

  if (GUARD_CYCLES < 2 || GUARD_CYCLES > 7) begin : g_guard_range_check
    $error("wash_controller: GUARD_CYCLES must be within 2..7");
  end

  state_t     cur_state;
  logic [2:0] guard_cnt;
  logic       start_r;
  logic       done_r;
  logic       lock_r;
  logic       qual_done;

  // The timer's Finished flag takes a cycle to clear after a restart, so
  // a stale flag is masked until the guard counter has run out.
  assign qual_done = bus.timer_done && (guard_cnt == 3'd0);

`ifdef DOUBLE_WASH_EN
  logic repeat_flag;
`else
  logic unused_double_wash;
  assign unused_double_wash = bus.double_wash;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state   <= IDLE;
      guard_cnt   <= 3'd0;
      start_r     <= 1'b0;
      done_r      <= 1'b0;
      lock_r      <= 1'b0;
`ifdef DOUBLE_WASH_EN
      repeat_flag <= 1'b0;
`endif
    end else begin
      start_r <= 1'b0;
      done_r  <= 1'b0;

      // Pause freezes the guard together with the timer. A timed-phase
      // entry below reloads the counter and overrides this decrement.
      if (guard_cnt != 3'd0 && cur_state != PAUSE) begin
        guard_cnt <= guard_cnt - 3'd1;
      end

      case (cur_state)
        IDLE: begin
          if (bus.coin_in) begin
            cur_state   <= FILL;
            start_r     <= 1'b1;
            guard_cnt   <= GUARD_LOAD;
            lock_r      <= 1'b1;
`ifdef DOUBLE_WASH_EN
            repeat_flag <= bus.double_wash;
`endif
          end
        end

        FILL: begin
          if (bus.cancel) begin
            // Drain spin: cancel wins over a simultaneous timer_done.
            cur_state   <= SPIN;
            start_r     <= 1'b1;
            guard_cnt   <= GUARD_LOAD;
`ifdef DOUBLE_WASH_EN
            repeat_flag <= 1'b0;
`endif
          end else if (qual_done) begin
            cur_state <= WASH;
            start_r   <= 1'b1;
            guard_cnt <= GUARD_LOAD;
          end
        end

        WASH: begin
          if (bus.cancel) begin
            cur_state   <= SPIN;
            start_r     <= 1'b1;
            guard_cnt   <= GUARD_LOAD;
`ifdef DOUBLE_WASH_EN
            repeat_flag <= 1'b0;
`endif
          end else if (qual_done) begin
            cur_state <= RINSE;
            start_r   <= 1'b1;
            guard_cnt <= GUARD_LOAD;
          end
        end

        RINSE: begin
          if (bus.cancel) begin
            cur_state   <= SPIN;
            start_r     <= 1'b1;
            guard_cnt   <= GUARD_LOAD;
`ifdef DOUBLE_WASH_EN
            repeat_flag <= 1'b0;
`endif
          end else if (qual_done) begin
            start_r   <= 1'b1;
            guard_cnt <= GUARD_LOAD;
`ifdef DOUBLE_WASH_EN
            // The second Washing+Rinsing pair consumes the repeat flag.
            if (repeat_flag) begin
              cur_state   <= WASH;
              repeat_flag <= 1'b0;
            end else begin
              cur_state <= SPIN;
            end
`else
            cur_state <= SPIN;
`endif
          end
        end

        SPIN: begin
          // Cancel is ignored here because the machine is already draining.
          if (qual_done) begin
            cur_state <= IDLE;
            done_r    <= 1'b1;
            lock_r    <= 1'b0;
          end else if (bus.timer_pause) begin
            cur_state <= PAUSE;
          end
        end

        PAUSE: begin
          // Returning to Spinning does not pulse start_timer, so the timer
          // resumes its held count.
          if (bus.cancel) begin
            cur_state <= IDLE;
            lock_r    <= 1'b0;
          end else if (!bus.timer_pause) begin
            cur_state <= SPIN;
          end
        end

        default: begin
          cur_state <= IDLE;
          lock_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = cur_state;
  assign bus.start_timer = start_r;
  assign bus.wash_done   = done_r;
  assign bus.door_lock   = lock_r;

endmodule
`default_nettype wire

// File: tb/tb_wash_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_controller
// Description : Self-checking bench for wash_controller. It uses a table of
//               directed vectors, hand-written corner sequences and random
//               stimulus. A phase-queue reference model checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_controller;

  localparam int G = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  wash_controller_if ifc ();

  wash_controller #(.GUARD_CYCLES(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------
  // Reference model. The phases still to run are kept in a queue. Each
  // timed phase records how many running cycles have passed since entry.
  // --------------------------------------------------------------------
  logic [2:0] m_state;
  bit         m_start;
  bit         m_done;
  bit         m_lock;
  int         m_elapsed;
  int         m_todo[$];

  task automatic model_reset();
    m_state   = 3'd0;
    m_start   = 1'b0;
    m_done    = 1'b0;
    m_lock    = 1'b0;
    m_elapsed = G;
    m_todo.delete();
  endtask

  task automatic model_enter(input int ph);
    m_state   = 3'(ph);
    m_start   = 1'b1;
    m_elapsed = 0;
  endtask

  task automatic model_step(input bit c, input bit d, input bit p,
                            input bit x, input bit t);
    bit q;
    q = t && (m_elapsed >= G);
    m_start = 1'b0;
    m_done  = 1'b0;
    if (m_state != 3'd5) m_elapsed++;
    case (m_state)
      3'd0: if (c) begin
        m_todo.delete();
        m_todo.push_back(2);
        m_todo.push_back(3);
`ifdef DOUBLE_WASH_EN
        if (d) begin
          m_todo.push_back(2);
          m_todo.push_back(3);
        end
`endif
        m_todo.push_back(4);
        model_enter(1);
      end
      3'd1, 3'd2, 3'd3: begin
        if (x) begin
          m_todo.delete();
          model_enter(4);
        end else if (q && m_todo.size() > 0) begin
          model_enter(m_todo.pop_front());
        end
      end
      3'd4: begin
        if (q) begin
          m_state = 3'd0;
          m_done  = 1'b1;
        end else if (p) begin
          m_state = 3'd5;
        end
      end
      3'd5: begin
        if (x) m_state = 3'd0;
        else if (!p) m_state = 3'd4;
      end
      default: m_state = 3'd0;
    endcase
    m_lock = (m_state != 3'd0);
  endtask

  // --------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------
  function automatic logic [31:0] dut_out();
    return {26'd0, ifc.state, ifc.start_timer, ifc.wash_done, ifc.door_lock};
  endfunction

  function automatic logic [31:0] model_out();
    return {26'd0, m_state, m_start, m_done, m_lock};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit c, input bit d, input bit p,
                       input bit x, input bit t);
    ifc.coin_in     = c;
    ifc.double_wash = d;
    ifc.timer_pause = p;
    ifc.cancel      = x;
    ifc.timer_done  = t;
    @(posedge clk);
    model_step(c, d, p, x, t);
    @(negedge clk);
    check("model", dut_out(), model_out());
  endtask

  // Hold timer_done high until the model reaches the target phase.
  task automatic advance(input logic [2:0] tgt);
    int k;
    k = 0;
    while (m_state != tgt && k < 60) begin
      cycle(0, 0, 0, 0, 1);
      k++;
    end
    if (m_state != tgt) check("advance_timeout", 32'(m_state), 32'(tgt));
  endtask

  // --------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------
  typedef struct packed {
    bit         coin;
    bit         dw;
    bit         pse;
    bit         cnc;
    bit         td;
    logic [2:0] st;
    bit         start;
    bit         done;
    bit         lock;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(bit c, bit p, bit x, bit t, logic [2:0] s,
                              bit st, bit dn, bit lk);
    vec_t v;
    v.coin = c; v.dw = 1'b0; v.pse = p; v.cnc = x; v.td = t;
    v.st = s; v.start = st; v.done = dn; v.lock = lk;
    return v;
  endfunction

  initial begin
    logic [31:0] seq;
    int          starts;
    int          dones;
    int          since;
    bit          fin;
    logic [2:0]  prev;

    clk = 1'b0;
    rst_n = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    ifc.coin_in = 0; ifc.double_wash = 0; ifc.timer_pause = 0;
    ifc.cancel = 0; ifc.timer_done = 0;
    model_reset();

    // Full cycle with timer_done held high (3 cycles per phase), then a
    // second cycle with cancel and timer_done together in Washing.
    vecs[0]  = mk(1, 0, 0, 0, 3'd1, 1, 0, 1);
    vecs[1]  = mk(0, 0, 0, 1, 3'd1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 3'd1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 1, 3'd2, 1, 0, 1);
    vecs[4]  = mk(0, 0, 0, 1, 3'd2, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 1, 3'd2, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 1, 3'd3, 1, 0, 1);
    vecs[7]  = mk(0, 0, 0, 1, 3'd3, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 3'd3, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 1, 3'd4, 1, 0, 1);
    vecs[10] = mk(0, 0, 0, 1, 3'd4, 0, 0, 1);
    vecs[11] = mk(0, 0, 0, 1, 3'd4, 0, 0, 1);
    vecs[12] = mk(0, 0, 0, 1, 3'd0, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 3'd0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 3'd1, 1, 0, 1);
    vecs[15] = mk(0, 0, 0, 1, 3'd1, 0, 0, 1);
    vecs[16] = mk(0, 0, 0, 1, 3'd1, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 1, 3'd2, 1, 0, 1);
    vecs[18] = mk(0, 0, 0, 0, 3'd2, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 3'd2, 0, 0, 1);
    vecs[20] = mk(0, 0, 1, 1, 3'd4, 1, 0, 1);
    vecs[21] = mk(0, 0, 1, 0, 3'd4, 0, 0, 1);
    vecs[22] = mk(0, 0, 0, 0, 3'd4, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 1, 3'd0, 0, 1, 0);
    vecs[24] = mk(0, 0, 0, 0, 3'd0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", dut_out(), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      ifc.coin_in     = vecs[i].coin;
      ifc.double_wash = vecs[i].dw;
      ifc.timer_pause = vecs[i].pse;
      ifc.cancel      = vecs[i].cnc;
      ifc.timer_done  = vecs[i].td;
      @(posedge clk);
      model_step(vecs[i].coin, vecs[i].dw, vecs[i].pse, vecs[i].cnc, vecs[i].td);
      @(negedge clk);
      check($sformatf("vec%0d", i), dut_out(),
            {26'd0, vecs[i].st, vecs[i].start, vecs[i].done, vecs[i].lock});
    end

    // timer_done pulsed 5 cycles after each start
    cycle(1, 0, 0, 0, 0);
    seq = 32'(ifc.state); prev = ifc.state;
    starts = int'(ifc.start_timer); dones = 0; since = 0; fin = 0;
    for (int k = 0; k < 200 && !fin; k++) begin
      since++;
      cycle(0, 0, 0, 0, since == 5);
      if (ifc.start_timer) begin starts++; since = 0; end
      if (ifc.state != prev) begin seq = (seq << 4) | 32'(ifc.state); prev = ifc.state; end
      if (ifc.wash_done) dones++;
      if (ifc.state == 3'd0) fin = 1;
    end
    check("pulse_timeout", 32'(fin), 32'd1);
    check("pulse_seq", seq, 32'h12340);
    check("pulse_starts", 32'(starts), 32'd4);
    check("pulse_dones", 32'(dones), 32'd1);

    // Pause and resume in Spinning, then cancel from Pause
    cycle(1, 0, 0, 0, 0);
    advance(3'd4);
    for (int k = 0; k < 10; k++) cycle(0, 0, 1, 0, 0);
    check("pause_hold", 32'(ifc.state), 32'd5);
    cycle(0, 0, 0, 0, 0);
    check("resume_no_start", dut_out(), {26'd0, 3'd4, 1'b0, 1'b0, 1'b1});
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    check("pause_cancel", dut_out(), 32'd0);

    // Asynchronous reset in the middle of Washing
    cycle(1, 0, 0, 0, 0);
    advance(3'd2);
    cycle(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_now", dut_out(), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("async_reset_held", dut_out(), 32'd0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 1);

    // Double wash request at coin acceptance
    cycle(1, 1, 0, 0, 0);
    seq = 32'(ifc.state); prev = ifc.state;
    starts = int'(ifc.start_timer); fin = 0;
    for (int k = 0; k < 100 && !fin; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (ifc.start_timer) starts++;
      if (ifc.state != prev) begin seq = (seq << 4) | 32'(ifc.state); prev = ifc.state; end
      if (ifc.state == 3'd0) fin = 1;
    end
    check("dw_timeout", 32'(fin), 32'd1);
`ifdef DOUBLE_WASH_EN
    check("dw_seq", seq, 32'h1232340);
    check("dw_starts", 32'(starts), 32'd6);
`else
    check("dw_seq", seq, 32'h12340);
    check("dw_starts", 32'(starts), 32'd4);
`endif

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 9) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
